// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^W) exponentiation engine and the SEED datapath.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Low byte of the SEED field polynomial x^8+x^6+x^5+x+1 (x^8 implicit)
  localparam logic [7:0] SEED_POLY = 8'h63;

  // Exponents used by the two SEED S-boxes
  localparam int SEED_S1_EXP = 247;
  localparam int SEED_S2_EXP = 251;

endpackage

// File: rtl/gf_pow_seq_if.sv
// Operand/result handshake bundle for gf_pow_seq.
interface gf_pow_seq_if #(
  parameter int W  = 8,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [EW-1:0] e;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  p;
  logic          busy;

  // Producer/consumer side (drives operands, takes results)
  modport master (
    output in_valid, a, e, out_ready,
    input  in_ready, out_valid, p, busy
  );

  // Exponentiation engine side
  modport slave (
    input  in_valid, a, e, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/gf_mul.sv
// Combinational GF(2^W) multiplier: carry-less product reduced by {1, POLY}.
module gf_mul #(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = 8'h63
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_p
);

  logic [W-1:0] w_prod;

  // Horner evaluation MSB first: shift-and-reduce, then conditionally add i_a
  always_comb begin
    w_prod = '0;
    for (int i = W - 1; i >= 0; i--) begin
      w_prod = {w_prod[W-2:0], 1'b0} ^ (w_prod[W-1] ? POLY : '0);
      if (i_b[i]) begin
        w_prod = w_prod ^ i_a;
      end
    end
  end

  assign o_p = w_prod;

endmodule

// File: rtl/gf_pow_seq.sv
// Sequential GF(2^W) exponentiation p = a^e, left-to-right square-and-multiply,
// one exponent bit per cycle, fixed EW-cycle latency regardless of data.
module gf_pow_seq
  import gf_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(SEED_POLY),
  parameter int           EW   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  gf_pow_seq_if.slave  bus
);

  localparam int CW = (EW > 1) ? $clog2(EW) : 1;

  state_t        r_state;
  state_t        w_next;
  logic          w_accept;

  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_base;
  logic [EW-1:0] r_exp;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_sq;
  logic [W-1:0]  w_mul;
  logic [W-1:0]  w_step;
  logic          w_bit;

  // Squarer and multiplier chained in one cycle; no internal pipelining
  gf_mul #(.W(W), .POLY(POLY)) u_sq (
    .i_a (r_acc),
    .i_b (r_acc),
    .o_p (w_sq)
  );

  gf_mul #(.W(W), .POLY(POLY)) u_mul (
    .i_a (w_sq),
    .i_b (r_base),
    .o_p (w_mul)
  );

  assign w_bit  = r_exp[r_cnt];
  assign w_step = w_bit ? w_mul : w_sq;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and handshake outputs decoded from the registered state
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand latch, accumulator update and MSB-first bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= W'(1);
      r_base <= '0;
      r_exp  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_base <= bus.a;
      r_exp  <= bus.e;
      r_acc  <= W'(1);
      r_cnt  <= CW'(EW - 1);
    end else if (r_state == RUN) begin
      r_acc <= w_step;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Accumulator is always visible; only meaningful while out_valid is high
  assign bus.p = r_acc;

endmodule

// File: tb/tb_gf_pow_seq.sv
// Testbench for gf_pow_seq: two parameter sets (GF(2^8)/SEED and GF(2^4)),
// scoreboard of expected powers from an independent software model.
module tb_gf_pow_seq;
  import gf_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [7:0] sb8[$];
  logic [3:0] sb4[$];

  gf_pow_seq_if #(.W(8), .EW(8)) if8 ();
  gf_pow_seq_if #(.W(4), .EW(4)) if4 ();

  gf_pow_seq #(.W(8), .POLY(8'h63), .EW(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  gf_pow_seq #(.W(4), .POLY(4'h3), .EW(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multiply: LSB-first shift-and-add with reduction of the shifted operand
  function automatic int mmul(input int x, input int y, input int w, input int poly);
    int r;
    int xs;
    r  = 0;
    xs = x;
    for (int i = 0; i < w; i++) begin
      if (((y >> i) & 1) != 0) r = r ^ xs;
      xs = xs << 1;
      if ((xs & (1 << w)) != 0) xs = xs ^ (1 << w) ^ poly;
    end
    return r;
  endfunction

  // Reference power: right-to-left binary exponentiation
  function automatic int mpow(input int x, input int e, input int w, input int poly);
    int r;
    int b;
    int k;
    r = 1;
    b = x;
    k = e;
    while (k != 0) begin
      if ((k & 1) != 0) r = mmul(r, b, w, poly);
      b = mmul(b, b, w, poly);
      k = k >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] ev, input int hold,
                      output logic [7:0] got);
    int         lat;
    logic       bad;
    logic [7:0] held;
    logic [7:0] expv;
    @(negedge clk);
    if8.a        = av;
    if8.e        = ev;
    if8.in_valid = 1'b1;
    if (if8.in_ready) sb8.push_back(8'(mpow(int'(av), int'(ev), 8, 'h63)));
    @(negedge clk);
    if8.in_valid = 1'b0;
    lat = 1;
    bad = 1'b0;
    while (!if8.out_valid && lat < 40) begin
      if (if8.in_ready || !if8.busy) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("lat8", 32'(lat), 32'd9);
    chk("run_in_ready8", 32'(bad), 32'd0);
    held = if8.p;
    bad  = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if8.in_valid = 1'b1;
      if8.a        = ~av;
      @(negedge clk);
      if (if8.p !== held || !if8.out_valid || if8.in_ready) bad = 1'b1;
    end
    if (hold > 0) chk("hold8", 32'(bad), 32'd0);
    expv = 'x;
    if (sb8.size() > 0) expv = sb8.pop_front();
    chk("p8", 32'(if8.p), 32'(expv));
    got           = if8.p;
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    @(negedge clk);
    if8.out_ready = 1'b0;
    chk("release8", 32'(if8.out_valid), 32'd0);
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] ev, output logic [3:0] got);
    int         lat;
    logic       bad;
    logic [3:0] expv;
    @(negedge clk);
    if4.a        = av;
    if4.e        = ev;
    if4.in_valid = 1'b1;
    if (if4.in_ready) sb4.push_back(4'(mpow(int'(av), int'(ev), 4, 'h3)));
    @(negedge clk);
    if4.in_valid = 1'b0;
    lat = 1;
    bad = 1'b0;
    while (!if4.out_valid && lat < 40) begin
      if (if4.in_ready || !if4.busy) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("lat4", 32'(lat), 32'd5);
    chk("run_in_ready4", 32'(bad), 32'd0);
    expv = 'x;
    if (sb4.size() > 0) expv = sb4.pop_front();
    chk("p4", 32'(if4.p), 32'(expv));
    got           = if4.p;
    if4.out_ready = 1'b1;
    @(negedge clk);
    if4.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] g8;
    logic [7:0] r8;
    logic [3:0] g4;
    logic [7:0] expv;
    int         acc_n;
    int         res_n;
    int         cyc;
    int         last;
    int         min_gap;
    logic       bad_ir;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.e = '0;
    if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = '0; if4.e = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready8",  32'(if8.in_ready),  32'd1);
    chk("rst_out_valid8", 32'(if8.out_valid), 32'd0);
    chk("rst_p8",         32'(if8.p),         32'd1);
    chk("rst_busy8",      32'(if8.busy),      32'd0);
    chk("rst_in_ready4",  32'(if4.in_ready),  32'd1);
    chk("rst_p4",         32'(if4.p),         32'd1);
    rst_n = 1'b1;

    // Basic power with output held for 3 cycles
    run8(8'h02, 8'd8, 3, g8);
    chk("basic_2pow8", 32'(g8), 32'h63);

    // Zero exponent / zero base
    run8(8'h00, 8'd0, 0, g8);
    chk("zero_pow_zero", 32'(g8), 32'h01);
    run8(8'hA5, 8'd0, 0, g8);
    chk("a5_pow_zero", 32'(g8), 32'h01);
    run8(8'h00, 8'd5, 0, g8);
    chk("zero_pow5", 32'(g8), 32'h00);

    // Field-order identities
    run8(8'h02, 8'd255, 0, g8);
    chk("2pow255", 32'(g8), 32'h01);
    run8(8'h02, 8'd1, 0, g8);
    chk("2pow1", 32'(g8), 32'h02);
    for (int i = 0; i < 20; i++) begin
      r8 = 8'($urandom_range(1, 255));
      run8(r8, 8'd254, 0, g8);
      chk("inverse_identity", 32'(mmul(int'(g8), int'(r8), 8, 'h63)), 32'd1);
    end

    // SEED S-box exponents over the whole field
    for (int i = 0; i < 256; i++) run8(8'(i), 8'(SEED_S1_EXP), 0, g8);
    for (int i = 0; i < 256; i++) run8(8'(i), 8'(SEED_S2_EXP), 0, g8);

    // Back-to-back with random output stalls
    acc_n = 0; res_n = 0; cyc = 0; last = -1; min_gap = 1000; bad_ir = 1'b0;
    while (res_n < 50 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if8.in_valid  = (acc_n < 50);
      if8.a         = 8'($urandom);
      if8.e         = 8'($urandom);
      if8.out_ready = 1'($urandom_range(0, 1));
      if (if8.in_ready && (if8.busy || if8.out_valid)) bad_ir = 1'b1;
      if (if8.in_valid && if8.in_ready) begin
        sb8.push_back(8'(mpow(int'(if8.a), int'(if8.e), 8, 'h63)));
        acc_n++;
      end
      if (if8.out_valid && if8.out_ready) begin
        expv = 'x;
        if (sb8.size() > 0) expv = sb8.pop_front();
        chk("b2b_p", 32'(if8.p), 32'(expv));
        res_n++;
        if (last >= 0 && (cyc - last) < min_gap) min_gap = cyc - last;
        last = cyc;
      end
    end
    @(negedge clk);
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b0;
    chk("b2b_results", 32'(res_n), 32'd50);
    chk("b2b_sb_empty", 32'(sb8.size()), 32'd0);
    chk("b2b_gap_ok", 32'(min_gap >= 10), 32'd1);
    chk("b2b_in_ready", 32'(bad_ir), 32'd0);
    repeat (12) @(negedge clk);
    chk("b2b_idle", 32'(if8.in_ready), 32'd1);

    // Reset during the 4th RUN cycle, then a fresh operation
    @(negedge clk);
    if8.a = 8'h03; if8.e = 8'hFF; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid8", 32'(if8.out_valid), 32'd0);
    chk("midrst_in_ready8",  32'(if8.in_ready),  32'd1);
    chk("midrst_p8",         32'(if8.p),         32'd1);
    chk("midrst_busy8",      32'(if8.busy),      32'd0);
    rst_n = 1'b1;
    run8(8'h53, 8'(SEED_S1_EXP), 0, g8);
    chk("after_rst8", 32'(g8), 32'(mpow('h53, SEED_S1_EXP, 8, 'h63)));

    // Second parameter set: GF(2^4), x^4+x+1, EW=4
    run4(4'h2, 4'd15, g4);
    chk("2pow15_gf16", 32'(g4), 32'h1);
    run4(4'h0, 4'd0, g4);
    chk("zero_pow_zero4", 32'(g4), 32'h1);
    run4(4'h0, 4'd5, g4);
    chk("zero_pow5_4", 32'(g4), 32'h0);
    run4(4'h2, 4'd4, g4);
    chk("2pow4_gf16", 32'(g4), 32'h3);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) run4(4'(i), 4'(j), g4);
    end

    @(negedge clk);
    if4.a = 4'h7; if4.e = 4'hF; if4.in_valid = 1'b1;
    @(negedge clk);
    if4.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid4", 32'(if4.out_valid), 32'd0);
    chk("midrst_in_ready4",  32'(if4.in_ready),  32'd1);
    chk("midrst_p4",         32'(if4.p),         32'd1);
    rst_n = 1'b1;
    run4(4'h9, 4'd11, g4);
    chk("after_rst4", 32'(g4), 32'(mpow('h9, 11, 4, 'h3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gf_pow_seq.md
# gf_pow_seq

Sequential, parametrised GF(2^W) exponentiation unit computing p = a^e mod POLY for a run-time exponent. It replaces fixed-exponent combinational power chains in the SEED S-box and key-schedule datapath with one square-and-multiply engine that is shared across exponents (for example x^247 for S1 and x^251 for S2). It uses a valid/ready handshake on both sides.

## Interface
- W, default 8: field width in bits; legal range 2..16.
- POLY, default 8'h63: low W bits of the field polynomial; the x^W term is implicit. The default gives x^8+x^6+x^5+x+1, the SEED field. POLY must be irreducible; the block does not check this.
- EW, default 8: exponent width in bits; legal range 1..16.

- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operand pair is present on a and e.
- in_ready  out  1  the block can accept an operand pair.
- a  in  W  base.
- e  in  EW  exponent, unsigned.
- out_valid  out  1  p holds a result.
- out_ready  in  1  the consumer takes p.
- p  out  W  result a^e.
- busy  out  1  high in RUN and DONE states.

## Operation
- **State machine.** States are IDLE, RUN and DONE.
  - IDLE: in_ready = 1. When in_valid is high, latch base = a, exp = e, acc = 1, cnt = EW-1, then go to RUN.
  - RUN: in_ready = 0. Each cycle computes sq = gf_mul(acc, acc), then sets acc <= exp[cnt] ? gf_mul(sq, base) : sq. This is left-to-right square-and-multiply, MSB first.
  - RUN exit: when cnt == 0, go to DONE after that update; otherwise decrement cnt.
  - DONE: out_valid = 1 and p = acc. When out_ready is high, go to IDLE.
- **No early exit.** Every exponent takes exactly EW RUN cycles, including leading-zero bits. Latency is therefore independent of the data.
- **Zero exponent.** e = 0 gives p = 1; this includes 0^0 = 1.
- **Zero base.** a = 0 with e ≠ 0 gives p = 0.
- **Output hold.** p and out_valid stay stable in DONE until out_ready is high. While in DONE, in_valid is ignored and in_ready = 0.
- **Outside DONE.** p = acc but carries no meaning; out_valid = 0.
- **Arithmetic.** gf_mul is carry-less multiplication followed by reduction by {1, POLY}. Operands and product are all W bits. No widening is visible outside the multiplier.
- **Reset.** Asserting rst_n low, including during RUN or DONE, aborts the current operation immediately. Reset values: state = IDLE, acc = 1, base = 0, exp = 0, cnt = 0. Outputs under reset: in_ready = 1, out_valid = 0, p = 1, busy = 0.
- **Deassertion.** Reset deassertion is assumed synchronised upstream. The first accept can happen on the first rising edge after rst_n goes high.

## Timing
- Accept happens on edge T0, when in_valid and in_ready are both high.
- RUN occupies the cycles after edges T0 .. T0+EW-1.
- out_valid is first high after edge T0+EW, so the latency is EW+1 cycles from the accept cycle to the first out_valid cycle.
- The earliest next accept is on the edge after the out handshake, because DONE → IDLE → accept. The peak rate is therefore one result per EW+2 cycles.
- The critical path is two chained gf_mul instances plus a mux. No internal pipelining.
- in_ready, out_valid and busy are decoded from registered state only. There are no combinational paths from input to output.

## Structure
- Shared package gf_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the constant SEED_POLY = 8'h63;
  - the exponent constants SEED_S1_EXP = 247 and SEED_S2_EXP = 251.
- Sub-module gf_mul (parameters W, POLY) is purely combinational: a × b mod {1, POLY}. It is instantiated twice, once as the squarer and once as the multiplier.
- The rest of the logic (FSM, counter, registers) lives in gf_pow_seq.

## Test plan
- **Basic power, output hold.** Defaults; a = 8'h02, e = 8; hold out_ready low for 3 cycles.
  - Required: p = 8'h63.
  - Required: out_valid rises exactly 9 cycles after the accept cycle.
  - Required: p stays stable while out_ready is low.
- **Zero exponent and zero base.**
  - e = 0, a = 8'h00 → p = 8'h01.
  - e = 0, a = 8'hA5 → p = 8'h01.
  - a = 8'h00, e = 5 → p = 8'h00.
- **Field-order identities.**
  - a = 8'h02, e = 255 → p = 8'h01.
  - a = 8'h02, e = 1 → p = 8'h02.
  - For 20 random nonzero a, a^254 × a = 1, checked against a software model.
- **SEED S-box exponents.** All 256 values of a with e = 247 and with e = 251. Results must match a software GF(2^8) reference model using POLY 8'h63.
- **Back-to-back with random stalls.** 50 operations, in_valid always high, out_ready random.
  - Required: no lost or duplicated results.
  - Required: in_ready = 0 throughout RUN and DONE.
  - Required: spacing between results is at least EW+2 cycles.
- **Reset mid-operation, plus a second parameter set.**
  - Assert rst_n low at the 4th RUN cycle. Required: the next cycle shows out_valid = 0, in_ready = 1, p = 1.
  - After release, a new operation completes correctly.
  - Repeat the whole plan with W = 4, POLY = 4'h3, EW = 4; a = 4'h2, e = 15 → p = 4'h1.
